// File: rtl/aud_codec_cfg_seq_if.sv
//============================================================================
// Module : aud_codec_cfg_seq_if
// Desc   : Start/status and I2C pin bundle of the WM8731 configuration
//          sequencer.
// Rev    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface aud_codec_cfg_seq_if;
  logic       start;
  logic       aud_scl;
  logic       sda_oe;
  logic       sda_in;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [3:0] err_idx;

  modport master (
    input  start, sda_in,
    output aud_scl, sda_oe, busy, done, ack_err, err_idx
  );

  modport slave (
    output start, sda_in,
    input  aud_scl, sda_oe, busy, done, ack_err, err_idx
  );
endinterface

`default_nettype wire

// File: rtl/aud_codec_cfg_seq.sv
//============================================================================
// Module : aud_codec_cfg_seq
// Desc   : Power-up I2C write sequencer for the 10-entry WM8731 register
//          table. Optional macro I2C_RETRY_EN: resend a NACKed word up to 3x.
// Rev    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module aud_codec_cfg_seq #(
  parameter int         CLK_HZ   = 50000000,
  parameter int         I2C_HZ   = 100000,
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         GAP_QTR  = 8
) (
  input  wire logic             clkin_50,
  input  wire logic             rst_n,
  aud_codec_cfg_seq_if.master   bus
);

  localparam int            c_QT       = CLK_HZ / (4 * I2C_HZ);
  localparam int            c_DW       = (c_QT > 1) ? $clog2(c_QT) : 1;
  localparam logic [c_DW-1:0] c_QT_LAST = c_DW'(c_QT - 1);
  localparam int            c_GW       = $clog2(GAP_QTR + 1);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_QTR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BITS, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [c_DW-1:0]   r_div;
  logic [c_GW-1:0]   r_gap;
  logic [1:0]        r_q;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte;
  logic [3:0]        r_idx;
  logic [7:0]        r_shift;
  logic              r_nack;
  logic              r_auto;
  logic              r_scl;
  logic              r_oe;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [3:0]        r_eidx;
`ifdef I2C_RETRY_EN
  logic [1:0]        r_retry;
`endif

  logic              w_qtick;
  logic              w_run;
  logic [15:0]       w_word;

  function automatic logic [15:0] f_word(input logic [3:0] i_idx);
    case (i_idx)
      4'd0:    f_word = 16'h1E00;
      4'd1:    f_word = 16'h0017;
      4'd2:    f_word = 16'h0217;
      4'd3:    f_word = 16'h0479;
      4'd4:    f_word = 16'h0679;
      4'd5:    f_word = 16'h0812;
      4'd6:    f_word = 16'h0A00;
      4'd7:    f_word = 16'h0C00;
      4'd8:    f_word = 16'h0E02;
      4'd9:    f_word = 16'h1201;
      default: f_word = 16'h0000;
    endcase
  endfunction

  assign w_word  = f_word(r_idx);
  assign w_qtick = (r_div == c_QT_LAST);
  // The reset-time run is launched by the first qtick; later runs by a start pulse.
  assign w_run   = ((r_state == S_IDLE) && ((r_auto && w_qtick) || bus.start)) ||
                   (((r_state == S_DONE) || (r_state == S_ERR)) && bus.start);

  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_gap   <= '0;
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
      r_byte  <= 2'd0;
      r_idx   <= 4'd0;
      r_shift <= 8'd0;
      r_nack  <= 1'b0;
      r_auto  <= 1'b1;
      r_scl   <= 1'b1;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_eidx  <= 4'd0;
`ifdef I2C_RETRY_EN
      r_retry <= 2'd0;
`endif
    end else begin
      if (!(r_busy || r_auto) || w_qtick) r_div <= '0;
      else                                r_div <= r_div + c_DW'(1);

      if (w_run) begin
        r_state <= S_START;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_eidx  <= 4'd0;
        r_idx   <= 4'd0;
        r_auto  <= 1'b0;
`ifdef I2C_RETRY_EN
        r_retry <= 2'd0;
`endif
      end else if (w_qtick) begin
        case (r_state)
          S_START: begin
            r_oe    <= 1'b1;
            r_state <= S_BITS;
            r_q     <= 2'd0;
            r_bit   <= 3'd7;
            r_byte  <= 2'd0;
            r_shift <= {DEV_ADDR, 1'b0};
            r_nack  <= 1'b0;
          end
          S_BITS: begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: begin r_scl <= 1'b0; r_oe <= ~r_shift[7]; end
              2'd1: r_scl <= 1'b1;
              2'd3: begin
                r_scl   <= 1'b0;
                r_shift <= {r_shift[6:0], 1'b0};
                if (r_bit == 3'd0) r_state <= S_ACK;
                else               r_bit   <= r_bit - 3'd1;
              end
              default: ;
            endcase
          end
          S_ACK: begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: r_oe   <= 1'b0;
              2'd1: r_scl  <= 1'b1;
              2'd2: r_nack <= bus.sda_in;
              default: begin
                r_scl <= 1'b0;
                if (r_nack || (r_byte == 2'd2)) begin
                  r_state <= S_STOP;
                end else begin
                  r_state <= S_BITS;
                  r_byte  <= r_byte + 2'd1;
                  r_bit   <= 3'd7;
                  r_shift <= (r_byte == 2'd0) ? w_word[15:8] : w_word[7:0];
                end
              end
            endcase
          end
          S_STOP: begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: r_oe  <= 1'b1;
              2'd1: r_scl <= 1'b1;
              2'd2: r_oe  <= 1'b0;
              default: begin
                r_gap <= '0;
                if (r_nack) begin
`ifdef I2C_RETRY_EN
                  if (r_retry == 2'd3) begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                    r_eidx  <= r_idx;
                    r_busy  <= 1'b0;
                  end else begin
                    r_retry <= r_retry + 2'd1;
                    r_state <= S_GAP;
                  end
`else
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_eidx  <= r_idx;
                  r_busy  <= 1'b0;
`endif
                end else begin
                  r_state <= S_GAP;
                end
              end
            endcase
          end
          S_GAP: begin
            if (r_gap == c_GAP_LAST) begin
              // r_nack still set here means this gap precedes a resend.
              if (r_nack) begin
                r_state <= S_START;
              end else if (r_idx == 4'd9) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_idx   <= r_idx + 4'd1;
                r_state <= S_START;
`ifdef I2C_RETRY_EN
                r_retry <= 2'd0;
`endif
              end
            end else begin
              r_gap <= r_gap + c_GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.aud_scl = r_scl;
  assign bus.sda_oe  = r_oe;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ack_err = r_err;
  assign bus.err_idx = r_eidx;

endmodule

`default_nettype wire

// File: tb/tb_aud_codec_cfg_seq.sv
//============================================================================
// Module : tb_aud_codec_cfg_seq
// Desc   : Bench for aud_codec_cfg_seq with an I2C codec slave model.
// Rev    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aud_codec_cfg_seq;
  localparam int c_FCLK = 2000000;
  localparam int c_FI2C = 100000;
  localparam int c_QT   = c_FCLK / (4 * c_FI2C);
`ifdef I2C_RETRY_EN
  localparam int c_RETRIES = 3;
`else
  localparam int c_RETRIES = 0;
`endif
  localparam logic [15:0] c_TBL [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
    16'h0679, 16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1201};

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
    logic        acked;
    int          rise_dly;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aud_codec_cfg_seq_if bus();
  aud_codec_cfg_seq_if dbus();

  aud_codec_cfg_seq #(.CLK_HZ(c_FCLK), .I2C_HZ(c_FI2C), .DEV_ADDR(7'h1A), .GAP_QTR(8))
    dut (.clkin_50(clk), .rst_n(rst_n), .bus(bus));
  aud_codec_cfg_seq dut_def (.clkin_50(clk), .rst_n(rst_n), .bus(dbus));

  // Default-rate instance only has its address byte observed; nobody ACKs it.
  assign dbus.sda_in = ~dbus.sda_oe;
  assign dbus.start  = 1'b0;

  // ---------------- codec slave model ----------------
  logic       ack_drv = 1'b0;
  logic       p_scl, p_sda, sda_l, in_x, slot;
  int         nbit, nbyte, xcyc, first_rise;
  logic [7:0] sh;
  logic [7:0] bytes [3];
  xfer_t      log_q [$];
  int         n_start = 0, n_stop = 0;
  logic [7:0] nack_hi = 8'hFF;
  int         nack_total = 0, nack_gen = 0, seen_gen = 0, nack_given = 0;

  assign bus.sda_in = ~(bus.sda_oe | ack_drv);

  always @(negedge clk) begin
    if (!rst_n) begin
      ack_drv = 1'b0; in_x = 1'b0; slot = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      sda_l = ~(bus.sda_oe | ack_drv);
      if (nack_gen != seen_gen) begin seen_gen = nack_gen; nack_given = 0; end
      if (p_scl && bus.aud_scl && p_sda && !sda_l) begin
        n_start++; in_x = 1'b1; nbit = 0; nbyte = 0; slot = 1'b0; xcyc = 0; first_rise = -1;
      end else if (p_scl && bus.aud_scl && !p_sda && sda_l) begin
        n_stop++; in_x = 1'b0;
      end else if (in_x) begin
        xcyc++;
        if (!p_scl && bus.aud_scl) begin
          if (first_rise < 0) first_rise = xcyc;
          if (!slot) begin sh = {sh[6:0], sda_l}; nbit++; end
        end else if (p_scl && !bus.aud_scl) begin
          if (slot) begin
            ack_drv = 1'b0; slot = 1'b0; nbit = 0; nbyte++;
          end else if (nbit == 8 && nbyte < 3) begin
            bytes[nbyte] = sh; slot = 1'b1; ack_drv = 1'b1;
            if (nbyte == 2) begin
              if (bytes[1] == nack_hi && nack_given < nack_total) begin
                ack_drv = 1'b0; nack_given++;
              end
              log_q.push_back('{bytes[0], {bytes[1], sh}, ack_drv, first_rise});
            end
          end
        end
      end
      p_scl = bus.aud_scl;
      p_sda = sda_l;
    end
  end

  // ---------------- reference model ----------------
  xfer_t exp_q [$];
  bit    exp_fail;
  int    exp_eidx;

  // Expected wire traffic for a run where word k is NACKed `nacks` times in a row.
  task automatic build_exp(input int k, input int nacks);
    xfer_t e;
    exp_q.delete(); exp_fail = 0; exp_eidx = 0;
    for (int i = 0; i < 10 && !exp_fail; i++) begin
      for (int a = 0; a <= c_RETRIES; a++) begin
        e.addr = 8'h34; e.word = c_TBL[i]; e.rise_dly = 2 * c_QT;
        e.acked = !((i == k) && (a < nacks));
        exp_q.push_back(e);
        if (e.acked) break;
        if (a == c_RETRIES) begin exp_fail = 1; exp_eidx = i; end
      end
    end
  endtask

  function automatic int log_mismatch(input int base);
    if (log_q.size() - base != exp_q.size()) return -2;
    foreach (exp_q[i])
      if (log_q[base+i].word !== exp_q[i].word || log_q[base+i].acked !== exp_q[i].acked)
        return i;
    return -1;
  endfunction

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!bus.busy && (bus.done || bus.ack_err)) begin ok = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.aud_scl !== 1'b1) begin bad++; $display("FAIL rst_scl: got %b want 1", bus.aud_scl); end
    total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", bus.sda_oe); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0 || bus.ack_err !== 1'b0)
      begin bad++; $display("FAIL rst_flags: got done=%b err=%b want 0/0", bus.done, bus.ack_err); end
    total++; if (bus.err_idx !== 4'd0) begin bad++; $display("FAIL rst_eidx: got %0d want 0", bus.err_idx); end
    rst_n = 1'b1;
  endtask

  task automatic test_bit_period();
    int t_rise [8];
    int t_fall [8];
    logic [7:0] a = 8'h00;
    bit to = 0;
    bit seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk); seen = dbus.aud_scl && dbus.sda_oe;
    end
    to = !seen;
    for (int b = 0; b < 8 && !to; b++) begin
      seen = 0;
      for (int i = 0; i < 1000 && !seen; i++) begin @(negedge clk); seen = !dbus.aud_scl; end
      t_fall[b] = cyc; to = !seen; seen = 0;
      for (int i = 0; i < 1000 && !seen && !to; i++) begin @(negedge clk); seen = dbus.aud_scl; end
      t_rise[b] = cyc; to = to || !seen;
      a = {a[6:0], ~dbus.sda_oe};
    end
    total++; if (to) begin bad++; $display("FAIL def_timeout: got timeout want 8 SCL pulses"); end
    total++; if (a !== 8'h34) begin bad++; $display("FAIL def_addr: got %h want 34", a); end
    total++; if (t_fall[2] - t_rise[1] != 250)
      begin bad++; $display("FAIL scl_high: got %0d want 250", t_fall[2] - t_rise[1]); end
    total++; if (t_rise[2] - t_fall[2] != 250)
      begin bad++; $display("FAIL scl_low: got %0d want 250", t_rise[2] - t_fall[2]); end
  endtask

  task automatic test_full_run(input int base, input int sbase);
    bit ok;
    int m, nerr;
    wait_end(ok);
    build_exp(-1, 0);
    m = log_mismatch(base);
    total++; if (!ok) begin bad++; $display("FAIL full_end: got timeout want done"); end
    total++; if (m != -1) begin bad++; $display("FAIL full_seq: got mismatch at %0d want none", m); end
    total++; if (bus.done !== 1'b1 || bus.ack_err !== 1'b0)
      begin bad++; $display("FAIL full_flags: got done=%b err=%b want 1/0", bus.done, bus.ack_err); end
    nerr = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].addr !== 8'h34 || log_q[i].rise_dly != 2 * c_QT) nerr++;
    total++; if (nerr != 0) begin bad++; $display("FAIL full_addr_rise: got %0d bad words want 0", nerr); end
    total++; if (n_start - sbase != 10)
      begin bad++; $display("FAIL full_starts: got %0d want 10", n_start - sbase); end
  endtask

  task automatic test_nack();
    bit ok;
    int k, nk, base, sbase, m;
    for (int it = 0; it < 3; it++) begin
      k  = (it == 0) ? 4 : int'($urandom_range(0, 9));
      nk = (it == 0) ? ((c_RETRIES > 0) ? 2 : 1) : int'($urandom_range(1, 4));
      nack_hi = c_TBL[k][15:8]; nack_total = nk; nack_gen++;
      base = log_q.size(); sbase = n_start;
      pulse_start();
      wait_end(ok);
      build_exp(k, nk);
      m = log_mismatch(base);
      total++; if (!ok) begin bad++; $display("FAIL nack_end k=%0d: got timeout want end", k); end
      total++; if (m != -1) begin bad++; $display("FAIL nack_seq k=%0d n=%0d: got mismatch at %0d want none", k, nk, m); end
      total++; if (bus.ack_err !== exp_fail || bus.done !== !exp_fail)
        begin bad++; $display("FAIL nack_flags k=%0d: got err=%b done=%b want err=%b", k, bus.ack_err, bus.done, exp_fail); end
      total++; if (bus.err_idx !== (exp_fail ? 4'(exp_eidx) : 4'd0))
        begin bad++; $display("FAIL nack_eidx: got %0d want %0d", bus.err_idx, exp_fail ? exp_eidx : 0); end
      if (exp_fail) begin
        repeat (2000) @(negedge clk);
        total++; if (n_start - sbase != exp_q.size() || n_stop - sbase != n_start - sbase)
          begin bad++; $display("FAIL nack_tail: got starts=%0d stops=%0d want %0d", n_start - sbase, n_stop - sbase, exp_q.size()); end
      end
    end
    nack_total = 0; nack_hi = 8'hFF; nack_gen++;
  endtask

  task automatic test_start_busy();
    bit ok, seen;
    int base, m;
    base = log_q.size();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin @(negedge clk); seen = (log_q.size() - base >= 6); end
    repeat ($urandom_range(0, 300)) @(negedge clk);
    total++; if (bus.busy !== 1'b1 || !seen) begin bad++; $display("FAIL busy_pre: got busy=%b want 1", bus.busy); end
    pulse_start();
    wait_end(ok);
    build_exp(-1, 0);
    m = log_mismatch(base);
    total++; if (!ok || m != -1 || bus.done !== 1'b1)
      begin bad++; $display("FAIL busy_ignore: got end=%b mismatch=%0d done=%b want 1/-1/1", ok, m, bus.done); end
  endtask

  task automatic test_start_done();
    bit ok;
    int base, m;
    base = log_q.size();
    pulse_start();
    repeat (2) @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1)
      begin bad++; $display("FAIL restart_flags: got done=%b busy=%b want 0/1", bus.done, bus.busy); end
    wait_end(ok);
    build_exp(-1, 0);
    m = log_mismatch(base);
    total++; if (!ok || m != -1) begin bad++; $display("FAIL restart_seq: got end=%b mismatch=%0d want 1/-1", ok, m); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int base, m;
    pulse_start();
    repeat ($urandom_range(300, 3000)) @(negedge clk);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = !bus.aud_scl && bus.sda_oe; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (!seen || bus.aud_scl !== 1'b1 || bus.sda_oe !== 1'b0)
      begin bad++; $display("FAIL async_rst: got scl=%b oe=%b want 1/0", bus.aud_scl, bus.sda_oe); end
    base = log_q.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_end(ok);
    build_exp(-1, 0);
    m = log_mismatch(base);
    total++; if (!ok || m != -1) begin bad++; $display("FAIL rst_rerun: got end=%b mismatch=%0d want 1/-1", ok, m); end
  endtask

  initial begin
    bus.start = 1'b0;
    rst_n = 1'b0;
    test_reset();
    fork
      test_full_run(0, 0);
      test_bit_period();
    join
    test_nack();
    test_start_busy();
    test_start_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
